alu_arbiter: RTL and testbench

//  Shares one ALU instance between two requesters (e.g. the decode unit and the test port).

---
 rtl/alu_arbiter.sv | 146 ++++++++++++++
 tb/tb_alu_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin share of one ALU between two requesters, with a
//               registered, tagged result on a valid/ready handshake.
// Revision    : 1.0  initial release
// ============================================================================
module alu_arbiter #(
    parameter int BITS  = 8,
    parameter int ALUOP = 4,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       reqValid,
    input  logic [ALUOP-1:0] reqOp0,
    input  logic [ALUOP-1:0] reqOp1,
    input  logic [BITS-1:0]  reqA0,
    input  logic [BITS-1:0]  reqA1,
    input  logic [BITS-1:0]  reqB0,
    input  logic [BITS-1:0]  reqB1,
    output logic [1:0]       reqAck,
    output logic             respValid,
    input  logic             respReady,
    output logic [BITS-1:0]  respData,
    output logic             respId,
    output logic             respError,
    output logic             busy,
    output logic [CNTW-1:0]  opsDone
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [ALUOP-1:0] c_OP_ADD = ALUOP'(1);
    localparam logic [ALUOP-1:0] c_OP_SUB = ALUOP'(2);
    localparam logic [ALUOP-1:0] c_OP_XOR = ALUOP'(3);
    localparam logic [ALUOP-1:0] c_OP_AND = ALUOP'(4);
    localparam logic [ALUOP-1:0] c_OP_OR  = ALUOP'(5);
    localparam logic [ALUOP-1:0] c_OP_SHL = ALUOP'(6);
    localparam logic [ALUOP-1:0] c_OP_SHR = ALUOP'(7);
    localparam logic [ALUOP-1:0] c_OP_ROR = ALUOP'(8);
    localparam logic [ALUOP-1:0] c_OP_ROL = ALUOP'(9);

    logic [1:0]       r_state;
    logic [1:0]       w_nextState;
    logic             r_lastGrant;
    logic             w_grant;
    logic [ALUOP-1:0] r_op;
    logic [BITS-1:0]  r_a;
    logic [BITS-1:0]  r_b;
    logic             r_id;
    logic [BITS-1:0]  w_result;
    logic             w_illegal;
    logic [31:0]      w_bWide;
    logic             w_shiftOk;
    logic             w_rotOk;
    logic [2*BITS-1:0] w_rorWide;
    logic [2*BITS-1:0] w_rolWide;

    assign respValid = (r_state == c_DONE);
    assign busy      = (r_state != c_IDLE);

    // Arbitration and next-state; a lone requester always wins, a tie goes
    // to whoever did not win last time.
    always_comb begin
        w_nextState = r_state;
        w_grant     = 1'b0;
        reqAck      = 2'b00;
        case (r_state)
            c_IDLE: begin
                if (reqValid != 2'b00) begin
                    w_grant     = (reqValid == 2'b11) ? ~r_lastGrant : reqValid[1];
                    reqAck      = w_grant ? 2'b10 : 2'b01;
                    w_nextState = c_EXEC;
                end
            end
            c_EXEC:  w_nextState = c_DONE;
            c_DONE:  if (respReady) w_nextState = c_IDLE;
            default: w_nextState = c_IDLE;
        endcase
    end

    assign w_bWide   = 32'(r_b);
    assign w_shiftOk = (w_bWide < 32'(BITS));
    assign w_rotOk   = (w_bWide != 32'd0) && w_shiftOk;
    assign w_rorWide = {r_a, r_a} >> r_b;
    assign w_rolWide = {r_a, r_a} << r_b;

    always_comb begin
        w_result  = '0;
        w_illegal = 1'b0;
        case (r_op)
            c_OP_ADD: w_result = r_a + r_b;
            c_OP_SUB: w_result = r_a - r_b;
            c_OP_XOR: w_result = r_a ^ r_b;
            c_OP_AND: w_result = r_a & r_b;
            c_OP_OR:  w_result = r_a | r_b;
            c_OP_SHL: w_result = w_shiftOk ? (r_a << r_b) : '0;
            c_OP_SHR: w_result = w_shiftOk ? (r_a >> r_b) : '0;
            c_OP_ROR: w_result = w_rotOk ? w_rorWide[BITS-1:0] : r_a;
            c_OP_ROL: w_result = w_rotOk ? w_rolWide[2*BITS-1:BITS] : r_a;
            default:  w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_lastGrant <= 1'b1;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_id        <= 1'b0;
            respData    <= '0;
            respId      <= 1'b0;
            respError   <= 1'b0;
            opsDone     <= '0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                c_IDLE: begin
                    if (reqValid != 2'b00) begin
                        r_op        <= w_grant ? reqOp1 : reqOp0;
                        r_a         <= w_grant ? reqA1 : reqA0;
                        r_b         <= w_grant ? reqB1 : reqB0;
                        r_id        <= w_grant;
                        r_lastGrant <= w_grant;
                    end
                end
                c_EXEC: begin
                    respData  <= w_result;
                    respId    <= r_id;
                    respError <= w_illegal;
                end
                c_DONE: begin
                    if (respReady) opsDone <= opsDone + CNTW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter against a transaction
//               level arbitration and arithmetic model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  reqValid;
    logic [3:0]  reqOp0, reqOp1;
    logic [7:0]  reqA0, reqA1, reqB0, reqB1;
    logic [1:0]  reqAck;
    logic        respValid;
    logic        respReady;
    logic [7:0]  respData;
    logic        respId;
    logic        respError;
    logic        busy;
    logic [15:0] opsDone;

    int checks   = 0;
    int failures = 0;
    int lastG    = 1;
    int expOps   = 0;

    alu_arbiter #(.BITS(8), .ALUOP(4), .CNTW(16)) dut (
        .clk(clk), .reset(reset), .reqValid(reqValid),
        .reqOp0(reqOp0), .reqOp1(reqOp1),
        .reqA0(reqA0), .reqA1(reqA1), .reqB0(reqB0), .reqB1(reqB1),
        .reqAck(reqAck), .respValid(respValid), .respReady(respReady),
        .respData(respData), .respId(respId), .respError(respError),
        .busy(busy), .opsDone(opsDone)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Result of one operation computed with plain integer arithmetic.
    function automatic logic [7:0] refAlu(input int op, input int a, input int b, output logic err);
        int r;
        err = 1'b0;
        case (op)
            1: r = (a + b) % 256;
            2: r = (a - b + 256) % 256;
            3: r = a ^ b;
            4: r = a & b;
            5: r = a | b;
            6: r = (b >= 8) ? 0 : (a * (1 << b)) % 256;
            7: r = (b >= 8) ? 0 : a / (1 << b);
            8: r = (b >= 1 && b <= 7) ? a / (1 << b) + (a * (1 << (8 - b))) % 256 : a;
            9: r = (b >= 1 && b <= 7) ? (a * (1 << b)) % 256 + a / (1 << (8 - b)) : a;
            default: begin r = 0; err = 1'b1; end
        endcase
        return 8'(r);
    endfunction

    // One full transaction starting in IDLE, one time unit after a rising edge.
    task automatic doOp(input logic [1:0] v, input int op0, input int a0, input int b0,
                        input int op1, input int a1, input int b1,
                        input int stall, input bit keep);
        int g;
        logic err;
        logic [7:0] expD;
        reqValid = v;
        reqOp0 = 4'(op0); reqA0 = 8'(a0); reqB0 = 8'(b0);
        reqOp1 = 4'(op1); reqA1 = 8'(a1); reqB1 = 8'(b1);
        respReady = (stall == 0);
        #1;
        g = (v == 2'b11) ? 1 - lastG : ((v == 2'b10) ? 1 : 0);
        chk("ackGrant", 32'(reqAck), (g == 0) ? 32'd1 : 32'd2);
        chk("busyIdle", 32'(busy), 32'd0);
        expD = (g == 1) ? refAlu(op1, a1, b1, err) : refAlu(op0, a0, b0, err);
        @(posedge clk); #1;
        lastG = g;
        if (!keep) reqValid = 2'b00;
        chk("execAck", 32'(reqAck), 32'd0);
        chk("execValid", 32'(respValid), 32'd0);
        chk("execBusy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("doneValid", 32'(respValid), 32'd1);
        chk("respData", 32'(respData), 32'(expD));
        chk("respId", 32'(respId), 32'(g));
        chk("respError", 32'(respError), 32'(err));
        for (int i = 0; i < stall; i++) begin
            reqValid = 2'b11;
            #1;
            chk("stallAck", 32'(reqAck), 32'd0);
            @(posedge clk); #1;
            chk("stallValid", 32'(respValid), 32'd1);
            chk("stallBusy", 32'(busy), 32'd1);
            chk("stallData", 32'(respData), 32'(expD));
            chk("stallId", 32'(respId), 32'(g));
            chk("stallErr", 32'(respError), 32'(err));
        end
        respReady = 1'b1;
        @(posedge clk); #1;
        expOps = (expOps + 1) % 65536;
        chk("retBusy", 32'(busy), 32'd0);
        chk("retValid", 32'(respValid), 32'd0);
        chk("opsDone", 32'(opsDone), 32'(expOps));
    endtask

    initial begin
        reset = 1'b1; reqValid = 2'b00; respReady = 1'b0;
        reqOp0 = '0; reqOp1 = '0; reqA0 = '0; reqA1 = '0; reqB0 = '0; reqB1 = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("rstAck", 32'(reqAck), 32'd0);
        chk("rstValid", 32'(respValid), 32'd0);
        chk("rstData", 32'(respData), 32'd0);
        chk("rstId", 32'(respId), 32'd0);
        chk("rstErr", 32'(respError), 32'd0);
        chk("rstBusy", 32'(busy), 32'd0);
        chk("rstOps", 32'(opsDone), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Both requesters continuously valid: alternating grants, 3 cycles each.
        for (int i = 0; i < 4; i++)
            doOp(2'b11, 1, 16 * i, 3, 5, 8'hA0, i, 0, 1'b1);
        reqValid = 2'b00;

        doOp(2'b01, 1, 8'h0F, 8'h01, 0, 0, 0, 0, 1'b0);
        doOp(2'b10, 0, 0, 0, 8, 8'b1000_0001, 1, 0, 1'b0);
        doOp(2'b10, 0, 0, 0, 2, 8'h00, 8'h01, 0, 1'b0);
        doOp(2'b01, 12, 8'h55, 8'h22, 0, 0, 0, 0, 1'b0);
        doOp(2'b01, 3, 8'h55, 8'h0F, 0, 0, 0, 0, 1'b0);
        doOp(2'b01, 6, 8'hFF, 8, 0, 0, 0, 0, 1'b0);
        doOp(2'b10, 0, 0, 0, 9, 8'hC3, 0, 0, 1'b0);
        doOp(2'b01, 5, 8'h12, 8'h34, 0, 0, 0, 10, 1'b0);

        for (int i = 0; i < 40; i++) begin
            int bs0, bs1;
            bs0 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 255));
            bs1 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 255));
            doOp(2'($urandom_range(1, 3)),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 255)), bs0,
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 255)), bs1,
                 int'($urandom_range(0, 3)), 1'b0);
        end

        // Reset while executing discards the operation.
        reqValid = 2'b01; reqOp0 = 4'd1; reqA0 = 8'h11; reqB0 = 8'h22; respReady = 1'b1;
        @(posedge clk); #1;
        reqValid = 2'b00;
        chk("preRstBusy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("asyncRstBusy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("midRstValid", 32'(respValid), 32'd0);
        chk("midRstBusy", 32'(busy), 32'd0);
        chk("midRstOps", 32'(opsDone), 32'd0);
        reset = 1'b0;
        lastG = 1;
        expOps = 0;
        @(posedge clk); #1;
        doOp(2'b11, 4, 8'hF0, 8'h3C, 1, 1, 1, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
